// File: rtl/tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tx_buffer
// Brief    : First-word-fall-through transmit buffer between the DLL and the
//            framing logic; exposes head and head+1 entries for 512-bit pops.
// Revision : 1.0 - initial release
// ============================================================================
module tx_buffer #(
    parameter int DATA_WIDTH       = 256,
    parameter int BUFFER_DEPTH     = 8,
    parameter int ADDR_WIDTH       = 3,
    parameter int PACKET_LENGTH    = 11,
    parameter int SYMBOL_PTR_WIDTH = 5
) (
    input  logic                        CLK,
    input  logic                        RST_L,
    input  logic                        Soft_RST_blocks,

    input  logic                        i_WR_EN,
    input  logic [0:DATA_WIDTH-1]       Data_IN,
    input  logic                        i_SOP,
    input  logic                        i_End_Valid,
    input  logic                        i_Type,
    input  logic [PACKET_LENGTH-1:0]    i_Length,
    input  logic [SYMBOL_PTR_WIDTH-1:0] i_Last_Byte,

    input  logic                        i_RD_EN,
    input  logic                        i_512_mode,

    output logic [0:DATA_WIDTH-1]       Data_Out1,
    output logic [0:DATA_WIDTH-1]       Data_Out2,
    output logic                        o_SOP1,
    output logic                        o_SOP2,
    output logic                        o_End_Valid1,
    output logic                        o_End_Valid2,
    output logic                        o_Type1,
    output logic                        o_Type2,
    output logic [PACKET_LENGTH-1:0]    o_Length1,
    output logic [PACKET_LENGTH-1:0]    o_Length2,
    output logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte1,
    output logic [SYMBOL_PTR_WIDTH-1:0] o_Last_Byte2,
    output logic                        o_Valid1,
    output logic                        o_Valid2,

    output logic                        o_Empty,
    output logic                        o_Full,
    output logic [ADDR_WIDTH:0]         o_Count,
    output logic                        o_Overflow,
    output logic                        o_Underflow
);

    // Entry word: {data, last_byte, length, SOP, End_Valid, Type}
    localparam int c_LEN_LO  = 3;
    localparam int c_LB_LO   = c_LEN_LO + PACKET_LENGTH;
    localparam int c_ENTRY_W = c_LB_LO + SYMBOL_PTR_WIDTH + DATA_WIDTH;

    localparam logic [ADDR_WIDTH:0]   c_DEPTH   = (ADDR_WIDTH+1)'(BUFFER_DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_TWO     = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0]   c_PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_IDX_ONE = ADDR_WIDTH'(1);

    logic [c_ENTRY_W-1:0]  r_mem [BUFFER_DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_valid1;
    logic                  w_valid2;
    logic                  w_wr_accept;
    logic [ADDR_WIDTH:0]   w_pop_num;
    logic [ADDR_WIDTH-1:0] w_wr_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx;
    logic [ADDR_WIDTH-1:0] w_rd_idx2;
    logic [c_ENTRY_W-1:0]  w_wr_word;
    logic [c_ENTRY_W-1:0]  w_head1;
    logic [c_ENTRY_W-1:0]  w_head2;

    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_empty     = (w_count == '0);
    assign w_full      = (w_count == c_DEPTH);
    assign w_valid1    = !w_empty;
    assign w_valid2    = i_512_mode && (w_count >= c_TWO);
    assign w_wr_accept = i_WR_EN && !w_full;
    // Pops are limited to what is valid, so a 512 pop of a single entry takes one
    assign w_pop_num   = i_RD_EN ? ((ADDR_WIDTH+1)'(w_valid1) + (ADDR_WIDTH+1)'(w_valid2))
                                 : '0;

    assign w_wr_idx    = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_idx    = r_rd_ptr[ADDR_WIDTH-1:0];
    assign w_rd_idx2   = w_rd_idx + c_IDX_ONE;

    assign w_wr_word   = {Data_IN, i_Last_Byte, i_Length, i_SOP, i_End_Valid, i_Type};
    assign w_head1     = r_mem[w_rd_idx];
    assign w_head2     = r_mem[w_rd_idx2];

    generate
        for (genvar e = 0; e < BUFFER_DEPTH; e++) begin : g_mem
            always_ff @(posedge CLK or negedge RST_L) begin
                if (!RST_L) begin
                    r_mem[e] <= '0;
                end else if (Soft_RST_blocks) begin
                    r_mem[e] <= '0;
                end else if (w_wr_accept && (w_wr_idx == ADDR_WIDTH'(e))) begin
                    r_mem[e] <= w_wr_word;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (Soft_RST_blocks) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_rd_ptr    <= r_rd_ptr + w_pop_num;
            r_overflow  <= i_WR_EN && w_full;
            r_underflow <= i_RD_EN && w_empty;
        end
    end

    assign Data_Out1    = w_head1[c_ENTRY_W-1 -: DATA_WIDTH];
    assign o_Last_Byte1 = w_head1[c_LB_LO +: SYMBOL_PTR_WIDTH];
    assign o_Length1    = w_head1[c_LEN_LO +: PACKET_LENGTH];
    assign o_SOP1       = w_head1[2];
    assign o_End_Valid1 = w_head1[1];
    assign o_Type1      = w_head1[0];

    assign Data_Out2    = w_head2[c_ENTRY_W-1 -: DATA_WIDTH];
    assign o_Last_Byte2 = w_head2[c_LB_LO +: SYMBOL_PTR_WIDTH];
    assign o_Length2    = w_head2[c_LEN_LO +: PACKET_LENGTH];
    assign o_SOP2       = w_head2[2];
    assign o_End_Valid2 = w_head2[1];
    assign o_Type2      = w_head2[0];

    assign o_Valid1     = w_valid1;
    assign o_Valid2     = w_valid2;
    assign o_Empty      = w_empty;
    assign o_Full       = w_full;
    assign o_Count      = w_count;
    assign o_Overflow   = r_overflow;
    assign o_Underflow  = r_underflow;

endmodule
`default_nettype wire

// File: doc/tx_buffer.md
TX_BUFFER -- requirements
Module: tx_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 256, data bits per entry.
REQ-002 SHALL have parameter BUFFER_DEPTH, 8, entries (power of two).
REQ-003 SHALL have parameter ADDR_WIDTH, 3, log2(BUFFER_DEPTH).
REQ-004 SHALL have parameter PACKET_LENGTH, 11, length field width in DW.
REQ-005 SHALL have parameter SYMBOL_PTR_WIDTH, 5, last-byte pointer width.
REQ-006 SHALL have port CLK  input  1  single clock, rising edge.
REQ-007 SHALL have port RST_L  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port Soft_RST_blocks  input  1  synchronous soft reset, active-high.
REQ-009 SHALL have port i_WR_EN  input  1  DLL write strobe, one entry per cycle.
REQ-010 SHALL have port Data_IN  input  [0:DATA_WIDTH-1]  DLL data.
REQ-011 SHALL have ports i_SOP, i_End_Valid, i_Type  input  1 each  packet indicators.
REQ-012 SHALL have ports i_Length  input  PACKET_LENGTH  and i_Last_Byte  input  SYMBOL_PTR_WIDTH.
REQ-013 SHALL have port i_RD_EN  input  1  framing-side pop strobe.
REQ-014 SHALL have port i_512_mode  input  1  framing consumes two entries per pop.
REQ-015 SHALL have ports Data_Out1, Data_Out2  output  [0:DATA_WIDTH-1]  head and head+1 entries.
REQ-016 SHALL have ports o_SOP1/2, o_End_Valid1/2, o_Type1/2 (1), o_Length1/2 (PACKET_LENGTH), o_Last_Byte1/2 (SYMBOL_PTR_WIDTH)  output  indicators of head / head+1.
REQ-017 SHALL have ports o_Valid1, o_Valid2  output  1  slot 1 / slot 2 content valid.
REQ-018 SHALL have ports o_Empty, o_Full  output  1, o_Count  output  ADDR_WIDTH+1  occupancy.
REQ-019 SHALL have ports o_Overflow, o_Underflow  output  1  registered one-cycle error pulses.

Function
REQ-020 Each entry SHALL store {data, last_byte, length, SOP, End_Valid, Type} as one word.
REQ-021 Pointers wr_ptr/rd_ptr SHALL be ADDR_WIDTH+1 bits, wrap mod 2*BUFFER_DEPTH, index memory with low ADDR_WIDTH bits.
REQ-022 o_Count SHALL equal wr_ptr - rd_ptr (mod 2^(ADDR_WIDTH+1)); o_Empty = (count==0); o_Full = (count==BUFFER_DEPTH).
REQ-023 Outputs SHALL be first-word-fall-through: slot1 = mem[rd_ptr], slot2 = mem[rd_ptr+1] (address wraps), combinational from state.
REQ-024 o_Valid1 = !o_Empty; o_Valid2 = i_512_mode && count>=2.
REQ-025 Write SHALL be accepted only when i_WR_EN && !o_Full (pre-edge state); write while full is dropped, memory and wr_ptr unchanged, o_Overflow=1 next cycle.
REQ-026 On i_RD_EN, rd_ptr SHALL advance by o_Valid1+o_Valid2 (0, 1 or 2); 512 mode with count==1 pops exactly 1.
REQ-027 i_RD_EN while empty SHALL leave rd_ptr unchanged and set o_Underflow=1 next cycle.
REQ-028 Simultaneous accepted write and pop SHALL both take effect; count changes by +1-pops.
REQ-029 A write to a full buffer coincident with a pop SHALL still be dropped (no pass-through).
REQ-030 Write-to-read latency SHALL be one cycle: entry written at edge N is visible on slot outputs after edge N.
REQ-031 o_Overflow/o_Underflow SHALL be high for exactly one cycle per offending cycle.

Reset
REQ-032 RST_L low SHALL asynchronously clear all memory, pointers, error flags: o_Empty=1, o_Full=0, o_Count=0, o_Valid1/2=0, all data/indicator outputs 0.
REQ-033 Soft_RST_blocks SHALL produce the same state at the next edge and take priority over write/read that cycle.
REQ-034 Reset asserted mid-operation SHALL discard all stored entries; no partial pop completes.

Verification
REQ-035 Write 3 entries (Data_IN=1,2,3), i_512_mode=0, pop each -> Data_Out1 reads 1,2,3; o_Empty=1 after third pop.
REQ-036 Write 5 entries, i_512_mode=1, pop x3 -> pairs (1,2),(3,4), then (5, o_Valid2=0); count 5->3->1->0.
REQ-037 Fill 8 entries, write 9th -> o_Full=1, 9th dropped, o_Overflow pulses once; then write+pop same cycle at full -> count 7, write dropped.
REQ-038 Pop on empty -> o_Underflow one cycle, count stays 0; write 6, pop 6, write 6 more -> pointer wrap, data order preserved.
REQ-039 With count=4, assert Soft_RST_blocks with i_WR_EN=1 -> count=0, o_Empty=1, all outputs 0; async RST_L pulse mid-cycle clears immediately.
